// File: rtl/nexi_pic_pkg.sv
// Shared definitions for the PIC and its CPU-side interrupt acknowledge initiator:
// register map, field widths, spurious vector and the initiator state encoding.
package nexi_pic_pkg;

  localparam int LVL_W  = 3;
  localparam int VEC_W  = 8;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] PIC_VERSION_ADDR = 3'd0;
  localparam logic [ADDR_W-1:0] PIC_CTRL_ADDR    = 3'd1;
  localparam logic [ADDR_W-1:0] PIC_STATUS_ADDR  = 3'd2;
  localparam logic [ADDR_W-1:0] PIC_VEC_ADDR     = 3'd3;
  localparam logic [ADDR_W-1:0] PIC_EOI_ADDR     = 3'd4;

  localparam logic [VEC_W-1:0] PIC_SPURIOUS_VEC = 8'h18;

  localparam logic [LVL_W-1:0] LVL_NMI = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_VEC  = 3'd1,
    ST_PRESENT = 3'd2,
    ST_SERVICE = 3'd3,
    ST_WR_EOI  = 3'd4
  } irq_state_e;

  // Level 7 is non-maskable: it is taken even when the mask is already 7.
  function automatic logic irq_accept(input logic [LVL_W-1:0] lvl,
                                      input logic [LVL_W-1:0] mask);
    return (lvl != '0) && ((lvl > mask) || (lvl == LVL_NMI));
  endfunction

endpackage

// File: rtl/nexi_wb_byte_master.sv
// Single-transfer Wishbone byte master: one start pulse launches one read or write,
// which ends on ack or after TIMEOUT cycles without ack.
module nexi_wb_byte_master
  import nexi_pic_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [VEC_W-1:0]  wdata,
  output logic              done,
  output logic              timeout,
  output logic [VEC_W-1:0]  rdata,
  output logic              cyc,
  output logic              stb,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [VEC_W-1:0]  bus_wdata,
  input  logic [VEC_W-1:0]  bus_rdata,
  input  logic              ack
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;

  // done/timeout are combinational so the sequencer reacts on the same edge the bus drops.
  assign done    = active && ack;
  assign timeout = active && !ack && (cnt == CNT_LAST);
  assign rdata   = bus_rdata;
  assign cyc     = active;
  assign stb     = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      cnt       <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (active) begin
      if (done || timeout) begin
        active    <= 1'b0;
        cnt       <= '0;
        bus_we    <= 1'b0;
        bus_addr  <= '0;
        bus_wdata <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (start) begin
      active    <= 1'b1;
      cnt       <= '0;
      bus_we    <= we;
      bus_addr  <= addr;
      bus_wdata <= wdata;
    end
  end

endmodule

// File: rtl/nexi_irq_ack.sv
// CPU-side interrupt initiator: takes a PIC level past the CPU mask, reads the vector,
// presents it to the core, and writes EOI once the core finishes service.
module nexi_irq_ack
  import nexi_pic_pkg::*;
#(
  parameter logic [ADDR_W-1:0] VEC_ADDR     = PIC_VEC_ADDR,
  parameter logic [ADDR_W-1:0] EOI_ADDR     = PIC_EOI_ADDR,
  parameter int                TIMEOUT      = 16,
  parameter logic [VEC_W-1:0]  SPURIOUS_VEC = PIC_SPURIOUS_VEC
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LVL_W-1:0]  irq_level_i,
  input  logic [LVL_W-1:0]  ipl_mask_i,
  input  logic              cpu_ack_i,
  input  logic              cpu_eoi_i,
  output logic              int_req_o,
  output logic [VEC_W-1:0]  int_vector_o,
  output logic [LVL_W-1:0]  int_level_o,
  output logic              busy_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [VEC_W-1:0]  data_o,
  input  logic [VEC_W-1:0]  data_i,
  input  logic              ack_i,
  output irq_state_e        state_o
);

  irq_state_e        state;
  logic [LVL_W-1:0]  lvl_q;

  logic              req_start;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [VEC_W-1:0]  req_wdata;

  logic              xfer_done;
  logic              xfer_timeout;
  logic [VEC_W-1:0]  xfer_rdata;

  assign busy_o  = (state != ST_IDLE);
  assign state_o = state;

  // Bus launches: vector read out of IDLE, EOI write out of SERVICE.
  always_comb begin
    req_start = 1'b0;
    req_we    = 1'b0;
    req_addr  = VEC_ADDR;
    req_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (irq_accept(lvl_q, ipl_mask_i)) begin
          req_start = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (cpu_eoi_i) begin
          req_start = 1'b1;
          req_we    = 1'b1;
          req_addr  = EOI_ADDR;
          req_wdata = {{(VEC_W-LVL_W){1'b0}}, int_level_o};
        end
      end
      default: ;
    endcase
  end

  nexi_wb_byte_master #(
    .TIMEOUT (TIMEOUT)
  ) u_master (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .start     (req_start),
    .we        (req_we),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .done      (xfer_done),
    .timeout   (xfer_timeout),
    .rdata     (xfer_rdata),
    .cyc       (cyc_o),
    .stb       (stb_o),
    .bus_we    (we_o),
    .bus_addr  (addr_o),
    .bus_wdata (data_o),
    .bus_rdata (data_i),
    .ack       (ack_i)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      lvl_q        <= '0;
      int_req_o    <= 1'b0;
      int_vector_o <= '0;
      int_level_o  <= '0;
    end else begin
      lvl_q <= irq_level_i;
      case (state)
        ST_IDLE: begin
          if (req_start) begin
            int_level_o <= lvl_q;
            state       <= ST_RD_VEC;
          end
        end
        ST_RD_VEC: begin
          if (xfer_done) begin
            int_vector_o <= xfer_rdata;
            state        <= ST_PRESENT;
          end else if (xfer_timeout) begin
            int_vector_o <= SPURIOUS_VEC;
            state        <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // Request rises one cycle after entry; a core ack only counts once it is visible.
          if (!int_req_o) begin
            int_req_o <= 1'b1;
          end else if (cpu_ack_i) begin
            int_req_o <= 1'b0;
            state     <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (req_start) begin
            state <= ST_WR_EOI;
          end
        end
        ST_WR_EOI: begin
          if (xfer_done || xfer_timeout) begin
            int_level_o <= '0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nexi_irq_ack.sv
// Bench for nexi_irq_ack: a PIC bus responder and CPU driver around the DUT, with a
// scoreboard queue of expected bus cycles and vector presentations.
`timescale 1ns/1ps
module tb_nexi_irq_ack;
  import nexi_pic_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] irq_level = '0;
  logic [2:0] ipl_mask = '0;
  logic       cpu_ack = 1'b0;
  logic       cpu_eoi = 1'b0;
  logic       int_req;
  logic [7:0] int_vector;
  logic [2:0] int_level;
  logic       busy;
  logic       cyc;
  logic       stb;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata = '0;
  logic       ack = 1'b0;
  irq_state_e state;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  int         wait_states = 0;
  logic       no_ack_rd = 1'b0;
  logic       no_ack_wr = 1'b0;
  logic [7:0] resp_data = '0;

  always #5 clk = ~clk;

  nexi_irq_ack #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .irq_level_i  (irq_level),
    .ipl_mask_i   (ipl_mask),
    .cpu_ack_i    (cpu_ack),
    .cpu_eoi_i    (cpu_eoi),
    .int_req_o    (int_req),
    .int_vector_o (int_vector),
    .int_level_o  (int_level),
    .busy_o       (busy),
    .cyc_o        (cyc),
    .stb_o        (stb),
    .we_o         (we),
    .addr_o       (addr),
    .data_o       (wdata),
    .data_i       (rdata),
    .ack_i        (ack),
    .state_o      (state)
  );

  // ---------------- reference model ----------------
  function automatic bit model_accept(input logic [2:0] lvl, input logic [2:0] mask);
    int l;
    int m;
    l = lvl;
    m = mask;
    if (l == 0) return 1'b0;
    if (l == 7) return 1'b1;
    return l > m;
  endfunction

  function automatic logic [W-1:0] bus_ev(input logic w, input logic [2:0] a, input logic [7:0] d);
    return {2'b01, 2'b00, w, a, d};
  endfunction

  function automatic logic [W-1:0] present_ev(input logic [2:0] lvl, input logic [7:0] vec);
    return {2'b10, 3'b000, lvl, vec};
  endfunction

  // One full service: vector read at address 3, presentation, EOI write of the level at address 4.
  task automatic push_service(input logic [2:0] lvl, input logic [7:0] vec);
    exp_q.push_back(bus_ev(1'b0, 3'd3, 8'h00));
    exp_q.push_back(present_ev(lvl, vec));
    exp_q.push_back(bus_ev(1'b1, 3'd4, {5'b00000, lvl}));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- PIC bus responder ----------------
  initial begin : responder
    int wc;
    wc = 0;
    forever begin
      @(negedge clk);
      if (cyc && stb && !ack) begin
        if ((we && no_ack_wr) || (!we && no_ack_rd)) begin
          ack = 1'b0;
        end else if (wc < wait_states) begin
          wc++;
        end else begin
          ack   = 1'b1;
          rdata = resp_data;
        end
      end else begin
        ack = 1'b0;
        wc  = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic prev_cyc;
    logic prev_req;
    logic [W-1:0] e;
    prev_cyc = 1'b0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc || stb) check("cyc_eq_stb", stb, cyc);
      if (cyc && !prev_cyc) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bus: got 0x%0h expected none", bus_ev(we, addr, wdata));
        end else begin
          e = exp_q.pop_front();
          check("bus_cycle", bus_ev(we, addr, wdata), e);
        end
      end
      if (int_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got 0x%0h expected none", present_ev(int_level, int_vector));
        end else begin
          e = exp_q.pop_front();
          check("present", present_ev(int_level, int_vector), e);
        end
      end
      prev_cyc = cyc;
      prev_req = int_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string name, output int cycles);
    cycles = 0;
    while (!int_req && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (!int_req) begin
      tests++;
      fails++;
      $display("FAIL %s: int_req got 0 expected 1 within %0d cycles", name, cycles);
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic wait_cyc(input string name);
    int c;
    c = 0;
    while (!cyc && c < 50) begin
      @(negedge clk);
      c++;
    end
    check(name, cyc, 1'b1);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    cpu_ack = 1'b1;
    @(negedge clk);
    cpu_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    @(negedge clk);
    cpu_eoi = 1'b1;
    @(negedge clk);
    cpu_eoi = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int cyc_cnt;
    int k;
    int saw;
    logic [2:0] r_lvl;
    logic [2:0] r_mask;
    logic [7:0] r_data;
    bit r_to_rd;
    bit r_to_wr;

    tick(3);
    check("rst_int_req", int_req, 1'b0);
    check("rst_vector", int_vector, 8'h00);
    check("rst_level", int_level, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_cyc", cyc, 1'b0);
    check("rst_bus", {we, addr, wdata}, 12'h000);
    check("rst_state", state, ST_IDLE);
    rst_n = 1'b1;
    tick(2);

    // Level 3 over mask 2, one wait state, vector 0x41.
    ipl_mask = 3'd2;
    wait_states = 1;
    resp_data = 8'h41;
    push_service(3'd3, 8'h41);
    irq_level = 3'd3;
    wait_req("t1_req", cyc_cnt);
    check("t1_vector", int_vector, 8'h41);
    check("t1_level", int_level, 3'd3);
    irq_level = 3'd0;
    pulse_ack();
    check("t1_req_drop", int_req, 1'b0);
    check("t1_service", state, ST_SERVICE);
    tick(3);
    pulse_eoi();
    wait_idle("t1_idle");
    check("t1_level_clr", int_level, 3'd0);
    check("t1_data_clr", wdata, 8'h00);

    // Level equal to mask is held off; lowering the mask releases it.
    wait_states = 0;
    @(negedge clk);
    ipl_mask = 3'd2;
    irq_level = 3'd2;
    saw = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cyc || busy) saw = 1;
    end
    check("t2_masked", saw, 0);
    resp_data = 8'h22;
    push_service(3'd2, 8'h22);
    ipl_mask = 3'd1;
    k = 0;
    while (!cyc && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t2_unmask_lat", (k >= 1 && k <= 2), 1'b1);
    wait_req("t2_req", cyc_cnt);
    irq_level = 3'd0;
    pulse_ack();
    pulse_eoi();
    wait_idle("t2_idle");

    // Level 7 beats mask 7 and re-triggers only after the EOI write.
    @(negedge clk);
    ipl_mask = 3'd7;
    resp_data = 8'h70;
    push_service(3'd7, 8'h70);
    push_service(3'd7, 8'h71);
    irq_level = 3'd7;
    wait_req("t3_req1", cyc_cnt);
    resp_data = 8'h71;
    pulse_ack();
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc) saw = 1;
    end
    check("t3_no_early_rd", saw, 0);
    pulse_eoi();
    wait_req("t3_req2", cyc_cnt);
    check("t3_vector2", int_vector, 8'h71);
    irq_level = 3'd0;
    pulse_ack();
    pulse_eoi();
    wait_idle("t3_idle");

    // Vector read never acked: spurious vector after TIMEOUT cycles.
    @(negedge clk);
    ipl_mask = 3'd0;
    no_ack_rd = 1'b1;
    push_service(3'd5, 8'h18);
    irq_level = 3'd5;
    wait_cyc("t4_cyc");
    cyc_cnt = 0;
    while (cyc && cyc_cnt < 100) begin
      cyc_cnt++;
      @(negedge clk);
    end
    check("t4_cyc_len", cyc_cnt, TIMEOUT);
    wait_req("t4_req", cyc_cnt);
    check("t4_spurious", int_vector, 8'h18);
    no_ack_rd = 1'b0;
    irq_level = 3'd0;
    pulse_ack();
    pulse_eoi();
    wait_idle("t4_idle");

    // Level rises 3 -> 6 during service; the 6 waits for the EOI of 3.
    @(negedge clk);
    resp_data = 8'h33;
    push_service(3'd3, 8'h33);
    push_service(3'd6, 8'h66);
    irq_level = 3'd3;
    wait_req("t5_req1", cyc_cnt);
    resp_data = 8'h66;
    pulse_ack();
    irq_level = 3'd6;
    tick(10);
    check("t5_held", state, ST_SERVICE);
    check("t5_level3", int_level, 3'd3);
    pulse_eoi();
    wait_req("t5_req2", cyc_cnt);
    check("t5_level6", int_level, 3'd6);
    irq_level = 3'd0;
    pulse_ack();
    pulse_eoi();
    wait_idle("t5_idle");

    // Minimum latency with a zero-wait PIC.
    tick(2);
    resp_data = 8'h44;
    push_service(3'd4, 8'h44);
    @(negedge clk);
    irq_level = 3'd4;
    wait_req("t6_req", cyc_cnt);
    check("t6_latency", cyc_cnt, 4);
    irq_level = 3'd0;
    pulse_ack();
    pulse_eoi();
    wait_idle("t6_idle");

    // Asynchronous reset in the middle of the vector read.
    @(negedge clk);
    no_ack_rd = 1'b1;
    exp_q.push_back(bus_ev(1'b0, 3'd3, 8'h00));
    irq_level = 3'd5;
    wait_cyc("t7_cyc");
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_cyc_async", cyc, 1'b0);
    check("t7_stb_async", stb, 1'b0);
    check("t7_req_async", int_req, 1'b0);
    check("t7_state", state, ST_IDLE);
    irq_level = 3'd0;
    no_ack_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    check("t7_idle", busy, 1'b0);

    // Randomized levels, masks, wait states and timeouts.
    for (int i = 0; i < 30; i++) begin
      r_lvl = 3'($urandom_range(1, 7));
      r_mask = 3'($urandom_range(0, 7));
      r_data = 8'($urandom_range(0, 255));
      r_to_rd = ($urandom_range(0, 5) == 0);
      r_to_wr = ($urandom_range(0, 5) == 0);
      wait_states = $urandom_range(0, 3);
      @(negedge clk);
      if (model_accept(r_lvl, r_mask)) begin
        resp_data = r_data;
        no_ack_rd = r_to_rd;
        no_ack_wr = r_to_wr;
        push_service(r_lvl, r_to_rd ? 8'h18 : r_data);
        ipl_mask = r_mask;
        irq_level = r_lvl;
        wait_req("rand_req", cyc_cnt);
        irq_level = 3'd0;
        pulse_ack();
        tick($urandom_range(0, 4));
        pulse_eoi();
        wait_idle("rand_idle");
        no_ack_rd = 1'b0;
        no_ack_wr = 1'b0;
      end else begin
        ipl_mask = r_mask;
        irq_level = r_lvl;
        tick(12);
        check("rand_reject", busy, 1'b0);
        irq_level = 3'd0;
      end
      tick(2);
    end

    tick(5);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nexi_irq_ack.md
Name: nexi_irq_ack

Overview:
- CPU-side initiator counterpart of nexi_pic.
- Watches the 3-bit m68k-style priority level driven by the PIC and compares it against the CPU's current interrupt mask.
- On an accepted interrupt, runs a Wishbone master read of the PIC VECTOR_ACK register and presents the vector to the CPU core.
- After the CPU signals end-of-service, runs a Wishbone master write to the PIC EOI register.
- One instance per CPU.

Parameters:
- VEC_ADDR, 3'd3, PIC address of VECTOR_ACK register (byte read)
- EOI_ADDR, 3'd4, PIC address of EOI register (byte write)
- TIMEOUT, 16, bus cycles to wait for ack_i before abandoning a transfer (≥2)
- SPURIOUS_VEC, 8'h18, vector presented when the vector read times out

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- irq_level_i  in  3  priority level from PIC irq_o (0 = none)
- ipl_mask_i  in  3  CPU status-register interrupt mask
- cpu_ack_i  in  1  CPU accepted presented interrupt (1-cycle pulse)
- cpu_eoi_i  in  1  CPU finished service (RTE), 1-cycle pulse
- int_req_o  out  1  interrupt pending to CPU
- int_vector_o  out  8  vector number for CPU
- int_level_o  out  3  level being serviced; CPU loads it into its mask
- busy_o  out  1  high whenever not IDLE
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- addr_o  out  3  Wishbone address
- data_o  out  8  Wishbone write data
- data_i  in  8  Wishbone read data
- ack_i  in  1  Wishbone acknowledge

Behaviour:
- Async reset (rst_ni low):
  - state IDLE
  - every output 0; int_vector_o 8'h00
  - timeout counter 0
  - captured level 0
- irq_level_i is registered once (lvl_q) before use; all decisions use lvl_q.
- Accept condition, evaluated in IDLE only: lvl_q != 0 && (lvl_q > ipl_mask_i || lvl_q == 7).
- States and transitions:
  - IDLE:
    - on accept: latch lvl_q into int_level_o, assert cyc_o/stb_o, we_o=0, addr_o=VEC_ADDR; go to RD_VEC.
    - on accept, same cycle as rst_ni deassertion: no action until the following edge.
  - RD_VEC:
    - hold cyc_o/stb_o/addr_o stable until ack_i.
    - on ack_i: capture data_i into int_vector_o, drop cyc_o/stb_o next edge, go to PRESENT.
    - if the counter reaches TIMEOUT-1 without ack_i: drop cyc/stb, int_vector_o=SPURIOUS_VEC, go to PRESENT.
    - counter clears on every state entry.
  - PRESENT:
    - int_req_o=1 (asserted the cycle after the vector is captured).
    - on cpu_ack_i: int_req_o=0, go to SERVICE.
    - level changes on irq_level_i are ignored here.
  - SERVICE:
    - wait for cpu_eoi_i.
    - on cpu_eoi_i: assert cyc_o/stb_o/we_o, addr_o=EOI_ADDR, data_o={5'b0,int_level_o}; go to WR_EOI.
  - WR_EOI:
    - hold until ack_i, or until the timeout (same rule as RD_VEC; the timeout is silent).
    - then drop cyc/stb/we, clear data_o and int_level_o, go to IDLE.
    - the next accept may occur in the cycle after returning to IDLE.
- Only one interrupt is outstanding at a time; there is no nesting. A higher level arriving during service waits until IDLE.
- cpu_ack_i outside PRESENT and cpu_eoi_i outside SERVICE are ignored.
- ack_i outside RD_VEC/WR_EOI is ignored. cyc_o==stb_o always.
- Minimum latency, accept to int_req_o with zero-wait PIC:
  - lvl_q register: 1 cycle
  - IDLE→RD_VEC: 1 cycle
  - ack: 1 cycle
  - PRESENT: 1 cycle
  - total: 4 cycles from irq_level_i change.
- Level 7 is accepted even when ipl_mask_i==7. It does not re-trigger until a full EOI has completed.

Decomposition:
- Shared package nexi_pic_pkg:
  - PIC register address constants (VEC_ADDR, EOI_ADDR, plus version/control/status)
  - level width (3)
  - vector width (8)
  - SPURIOUS_VEC
  - state encoding localparams
- Natural sub-module: nexi_wb_byte_master — single-transfer Wishbone master with start/we/addr/wdata inputs and done/rdata/timeout outputs. nexi_irq_ack instantiates it once, and the FSM sequences it.

Test Plan:
- Level 3 appears, mask 2, PIC acks read with data 8'h41 after 1 wait state:
  - cyc_o/stb_o with addr_o=3, we_o=0
  - int_vector_o=8'h41, int_req_o=1, int_level_o=3
  - cpu_ack_i then cpu_eoi_i → one write with addr_o=4, data_o=8'h03, then IDLE.
- Level 2 with mask 2 → no bus activity for 50 cycles; mask lowered to 1 → read cycle starts within 2 cycles.
- Level 7 with mask 7 → accepted. After EOI with level still 7, a second read starts; no read occurs before the EOI write completes.
- Vector read never acked, TIMEOUT=16 → cyc_o drops after 16 cycles, int_vector_o=8'h18, int_req_o=1.
- Level rises 3→6 during SERVICE → no new cycle until the EOI for level 3 completes, then a read with int_level_o=6.
- rst_ni pulsed low mid RD_VEC (stb_o high) → cyc_o/stb_o/int_req_o fall immediately (asynchronously), and the state returns to IDLE.
